// File: rtl/fsqrt_pkg.sv
// Shared types and binary64 constants for the FSQRT unit.
package fsqrt_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_ADD  = 3'd2,
    S_HALF = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF   = 64'h7FF0_0000_0000_0000;
  localparam int          EXP_BIAS  = 1023;

  // binary64 field positions
  localparam int SIGN_BIT = 63;
  localparam int EXP_MSB  = 62;
  localparam int EXP_LSB  = 52;
  localparam int MAN_MSB  = 51;
  localparam int MAN_LSB  = 0;

endpackage

// File: rtl/fsqrt_classify.sv
// Combinational binary64 operand classifier and special-case result for sqrt.
module fsqrt_classify
  import fsqrt_pkg::*;
(
  input  logic [63:0] in_a,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_neg,
  output logic [63:0] special_res
);

  logic [EXP_MSB-EXP_LSB:0] w_exp;
  logic [MAN_MSB-MAN_LSB:0] w_man;

  assign w_exp   = in_a[EXP_MSB:EXP_LSB];
  assign w_man   = in_a[MAN_MSB:MAN_LSB];
  assign is_zero = (w_exp == '0) && (w_man == '0);
  assign is_sub  = (w_exp == '0) && (w_man != '0);
  assign is_inf  = (w_exp == '1) && (w_man == '0);
  assign is_nan  = (w_exp == '1) && (w_man != '0);
  assign is_neg  = in_a[SIGN_BIT];

  // Priority: signed zero passes through, subnormals flush to signed zero,
  // NaN and any other negative value give the canonical NaN, +Inf maps to itself.
  always_comb begin
    special_res = '0;
    if (is_zero)               special_res = in_a;
    else if (is_sub)           special_res = {in_a[SIGN_BIT], 63'h0};
    else if (is_nan || is_neg) special_res = CANON_NAN;
    else if (is_inf)           special_res = POS_INF;
  end

endmodule

// File: rtl/fsqrt_nr_ctrl.sv
// Newton-Raphson (Heron) square-root sequencer around an external FP divider and adder.
module fsqrt_nr_ctrl
  import fsqrt_pkg::*;
#(
  parameter int ITER = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_res,
  output logic [63:0] div_n,
  output logic [63:0] div_d,
  input  logic [63:0] div_q,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  input  logic [63:0] add_s
);

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t      r_state, w_next;
  logic [63:0] r_a, r_x, r_q, r_s, r_res;
  logic [3:0]  r_iter;

  logic        w_zero, w_sub, w_inf, w_nan, w_neg, w_special;
  logic [63:0] w_spec_res;
  logic [11:0] w_exp_sum;
  logic [10:0] w_x0_exp;
  logic [10:0] w_s_exp;
  logic [63:0] w_half_x;
  logic        w_last;

  fsqrt_classify u_classify (
    .in_a        (in_a),
    .is_zero     (w_zero),
    .is_sub      (w_sub),
    .is_inf      (w_inf),
    .is_nan      (w_nan),
    .is_neg      (w_neg),
    .special_res (w_spec_res)
  );

  assign w_special = w_zero | w_sub | w_inf | w_nan | w_neg;

  // Seed: 1.0 scaled by roughly half the unbiased exponent; within 2x of the root.
  assign w_exp_sum = {1'b0, in_a[EXP_MSB:EXP_LSB]} + 12'(EXP_BIAS);
  assign w_x0_exp  = 11'(w_exp_sum >> 1);

  // Halving by exponent decrement; a zero exponent field is left alone.
  assign w_s_exp  = r_s[EXP_MSB:EXP_LSB];
  assign w_half_x = (w_s_exp == '0) ? r_s
                                    : {r_s[SIGN_BIT], w_s_exp - 11'd1, r_s[MAN_MSB:MAN_LSB]};
  assign w_last   = (r_iter == LAST_ITER);

  assign div_n   = r_a;
  assign div_d   = r_x;
  assign add_a   = r_x;
  assign add_b   = r_q;
  assign out_res = r_res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = w_special ? S_DONE : S_DIV;
      S_DIV:  w_next = S_ADD;
      S_ADD:  w_next = S_HALF;
      S_HALF: w_next = w_last ? S_DONE : S_DIV;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath registers: operand latch, estimate, quotient, sum, counter, result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_x    <= '0;
      r_q    <= '0;
      r_s    <= '0;
      r_res  <= '0;
      r_iter <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= in_a;
          if (w_special) r_res <= w_spec_res;
          else begin
            r_x    <= {1'b0, w_x0_exp, 52'h0};
            r_iter <= '0;
          end
        end
        S_DIV: r_q <= div_q;
        S_ADD: r_s <= add_s;
        S_HALF: begin
          r_x <= w_half_x;
          if (w_last) r_res  <= w_half_x;
          else        r_iter <= r_iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsqrt_nr_ctrl.sv
// Self-checking bench for fsqrt_nr_ctrl with real-valued divider/adder models.
module tb_fsqrt_nr_ctrl;

  localparam int ITER     = 6;
  localparam int NORM_LAT = 3 * ITER + 1;
  localparam int LAT_MAX  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_a, out_res;
  logic [63:0] div_n, div_d, div_q, add_a, add_b, add_s;

  int checks = 0;
  int errors = 0;

  fsqrt_nr_ctrl #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .div_n(div_n), .div_d(div_d), .div_q(div_q),
    .add_a(add_a), .add_b(add_b), .add_s(add_s)
  );

  always #5 clk = ~clk;

  // Combinational arithmetic units modelled with host doubles
  assign div_q = $realtobits($bitstoreal(div_n) / $bitstoreal(div_d));
  assign add_s = $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] res;
    int          lat;
    int          tol;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_ulp(input string nm, input logic [63:0] act, input logic [63:0] exp_v,
                         input int tol);
    logic [63:0] d;
    checks++;
    d = (act > exp_v) ? act - exp_v : exp_v - act;
    if ((act[63] !== exp_v[63]) || (d > 64'(tol)) || $isunknown(act)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (+-%0d ulp)", nm, act, exp_v, tol);
    end
  endtask

  // Reference: IEEE special-case rules, otherwise the host's correctly rounded sqrt
  function automatic void ref_model(input logic [63:0] a, output logic [63:0] res,
                                    output int lat, output int tol);
    logic [10:0] e;
    logic [51:0] m;
    e = a[62:52];
    m = a[51:0];
    lat = 1;
    tol = 0;
    if (e == 0 && m == 0)          res = a;
    else if (e == 0)               res = {a[63], 63'h0};
    else if (e == 11'h7FF && m != 0) res = 64'h7FF8_0000_0000_0000;
    else if (a[63])                res = 64'h7FF8_0000_0000_0000;
    else if (e == 11'h7FF)         res = 64'h7FF0_0000_0000_0000;
    else begin
      res = $realtobits($sqrt($bitstoreal(a)));
      lat = NORM_LAT;
      tol = 1;
    end
  endfunction

  // Issue one operand from IDLE and wait for the result; counts cycles after acceptance
  task automatic run_op(input logic [63:0] a, output logic [63:0] res, output int lat,
                        output int busy_bad);
    busy_bad = 0;
    chk("ready_before_issue", {63'h0, in_ready}, 64'd1);
    in_a = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      if (in_ready) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_bad++;
    res = out_res;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_low_after_xfer", {63'h0, out_valid}, 64'd0);
    chk("ready_after_xfer", {63'h0, in_ready}, 64'd1);
  endtask

  task automatic check_vec(input vec_t v);
    logic [63:0] res;
    int lat, bad;
    run_op(v.a, res, lat, bad);
    chk({v.name, "_lat"}, 64'(lat), 64'(v.lat));
    chk_ulp({v.name, "_res"}, res, v.res, v.tol);
    chk({v.name, "_busy_ready"}, 64'(bad), 64'd0);
    release_out();
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [63:0] res, held, ra, rb, exp_r;
    int          lat, bad, cyc, xfer, acc2, e_lat, e_tol;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_out_res", out_res, 64'h0);
    chk("rst_x", div_d, 64'h0);
    chk("rst_q", add_b, 64'h0);

    // Directed vectors
    vecs.push_back('{"four",    64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000, NORM_LAT, 0});
    vecs.push_back('{"two",     64'h4000_0000_0000_0000, 64'h3FF6_A09E_667F_3BCD, NORM_LAT, 1});
    vecs.push_back('{"one",     64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, NORM_LAT, 1});
    vecs.push_back('{"tiny",    $realtobits(1e-300), $realtobits($sqrt(1e-300)), NORM_LAT, 1});
    vecs.push_back('{"huge",    $realtobits(1e300),  $realtobits($sqrt(1e300)),  NORM_LAT, 1});
    vecs.push_back('{"negzero", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0});
    vecs.push_back('{"poszero", 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1, 0});
    vecs.push_back('{"negone",  64'hBFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1, 0});
    vecs.push_back('{"posinf",  64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1, 0});
    vecs.push_back('{"neginf",  64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1, 0});
    vecs.push_back('{"snan",    64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0000, 1, 0});
    vecs.push_back('{"subn",    64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1, 0});
    vecs.push_back('{"negsubn", 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 1, 0});
    foreach (vecs[i]) check_vec(vecs[i]);

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [63:0] a;
      if ($urandom_range(0, 3) != 0)
        a = {1'b0, 11'($urandom_range(1, 2046)), 20'($urandom), $urandom};
      else
        a = {$urandom, $urandom};
      ref_model(a, exp_r, e_lat, e_tol);
      v = '{"rand", a, exp_r, e_lat, e_tol};
      check_vec(v);
    end

    // Backpressure: result and in_ready must hold while out_ready is low
    run_op(64'h4010_0000_0000_0000, held, lat, bad);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_res !== held) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    chk("bp_res", held, 64'h4000_0000_0000_0000);
    release_out();

    // Reset during HALF of iteration 3: the in-flight result must vanish
    chk("pre_rst_ready", {63'h0, in_ready}, 64'd1);
    in_a = 64'h4000_0000_0000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 9; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("midrst_out_res", out_res, 64'h0);
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) bad++;
    end
    chk("midrst_no_stale", 64'(bad), 64'd0);
    v = '{"nine", 64'h4022_0000_0000_0000, 64'h4008_0000_0000_0000, NORM_LAT, 1};
    check_vec(v);

    // Back-to-back with in_valid and out_ready held high
    in_a = 64'h4010_0000_0000_0000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    ra = '0; rb = '0;
    xfer = -1; acc2 = -1;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < LAT_MAX && acc2 < 0) begin
      if (out_valid && xfer < 0) begin xfer = cyc; ra = out_res; end
      if (in_ready) begin acc2 = cyc; in_a = 64'h4022_0000_0000_0000; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    while (cyc < 2 * LAT_MAX && !out_valid) begin @(posedge clk); #1; cyc++; end
    rb = out_res;
    chk("b2b_first_xfer", 64'(xfer), 64'(NORM_LAT));
    chk("b2b_second_accept", 64'(acc2), 64'(NORM_LAT + 1));
    chk("b2b_second_lat", 64'(cyc - acc2), 64'(NORM_LAT));
    chk("b2b_res_a", ra, 64'h4000_0000_0000_0000);
    chk_ulp("b2b_res_b", rb, 64'h4008_0000_0000_0000, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_idle", {63'h0, in_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
